// File: rtl/axis_rr_arb_mux.sv
// axis_rr_arb_mux: round-robin packet arbiter muxing N AXI-Stream inputs onto one registered output
module axis_rr_arb_mux #(
  parameter int N = 4,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*DATA_WIDTH-1:0]   s_data,
  input  logic [N*DATA_WIDTH/8-1:0] s_keep,
  input  logic [N*USER_WIDTH-1:0]   s_user,
  input  logic [N-1:0]              s_last,
  input  logic [N-1:0]              s_valid,
  output logic [N-1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic [DATA_WIDTH/8-1:0]   m_keep,
  output logic [USER_WIDTH-1:0]     m_user,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy
);
  localparam int KW = DATA_WIDTH / 8;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic [IDX_W-1:0] grant_nx, pick;
  logic found, en, acc;
  assign busy    = state == LOCKED;
  assign en      = !m_valid | m_ready;
  assign acc     = busy & en & s_valid[grant_idx];
  assign s_ready = (busy & en) ? {{(N-1){1'b0}}, 1'b1} << grant_idx : '0;
  // scan starts just past the last grant, so the previous winner is considered last
  always_comb begin
    pick  = grant_idx;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && s_valid[(int'(grant_idx) + k) % N]) begin
        found = 1'b1;
        pick  = IDX_W'((int'(grant_idx) + k) % N);
      end
    end
  end
  always_comb begin
    state_nx = state == IDLE ? (found ? LOCKED : IDLE) : ((acc & s_last[grant_idx]) ? IDLE : LOCKED);
    grant_nx = (state == IDLE && found) ? pick : grant_idx;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant_idx <= IDX_W'(N - 1);
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
      m_keep    <= '0;
      m_user    <= '0;
    end else begin
      state     <= state_nx;
      grant_idx <= grant_nx;
      if (en) m_valid <= acc;
      if (acc) begin
        m_data <= s_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        m_keep <= s_keep[grant_idx*KW +: KW];
        m_user <= s_user[grant_idx*USER_WIDTH +: USER_WIDTH];
        m_last <= s_last[grant_idx];
      end
    end
  end
endmodule

// File: tb/tb_axis_rr_arb_mux.sv
// tb_axis_rr_arb_mux: directed self-checking bench for the round-robin AXI-Stream packet mux
module tb_axis_rr_arb_mux;
  localparam int N = 4, DW = 32, UW = 2, KW = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic [N*DW-1:0] s_data;
  logic [N*KW-1:0] s_keep;
  logic [N*UW-1:0] s_user;
  logic [N-1:0] s_last, s_valid, s_ready;
  logic [DW-1:0] m_data;
  logic [KW-1:0] m_keep;
  logic [UW-1:0] m_user;
  logic m_last, m_valid, m_ready = 1'b1;
  logic [1:0] grant_idx;
  logic busy;
  logic [38:0] mem [N][32];
  int cnt [N], ptr [N];
  logic [N-1:0] hold;
  logic [38:0] log_q [$];
  logic bp_on = 1'b0;
  logic [31:0] bp_pat = 32'b1001_0110_1100_1010_0011_0101_1001_0011;
  int n_cmp = 0, n_bad = 0;
  logic [32:0] exp2 [10];
  axis_rr_arb_mux #(.N(N), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_keep(s_keep), .s_user(s_user),
    .s_last(s_last), .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
    .m_keep(m_keep), .m_user(m_user), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .grant_idx(grant_idx), .busy(busy));
  always #5 clk = ~clk;
  // each lane presents the head of its beat list; beat = {user, keep, last, data}
  always_comb begin
    for (int i = 0; i < N; i++) begin
      s_valid[i]         = ptr[i] < cnt[i] && !hold[i];
      s_data[i*DW +: DW] = mem[i][ptr[i] % 32][31:0];
      s_last[i]          = mem[i][ptr[i] % 32][32];
      s_keep[i*KW +: KW] = mem[i][ptr[i] % 32][36:33];
      s_user[i*UW +: UW] = mem[i][ptr[i] % 32][38:37];
    end
  end
  function automatic logic [38:0] bt(input logic [31:0] d, input logic l,
                                     input logic [3:0] k = 4'hF, input logic [1:0] u = 2'b01);
    return {u, k, l, d};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input int ln, input logic [38:0] b);
    mem[ln][cnt[ln]] = b;
    cnt[ln]++;
  endtask
  task automatic clr;
    for (int i = 0; i < N; i++) begin
      cnt[i] = 0;
      ptr[i] = 0;
    end
    hold = '0;
    log_q.delete();
  endtask
  task automatic step;
    logic [N-1:0] hs;
    logic mh, stall;
    logic [38:0] ob;
    @(negedge clk);
    hs    = s_valid & s_ready;
    mh    = m_valid & m_ready;
    stall = m_valid & !m_ready & rst;
    ob    = {m_user, m_keep, m_last, m_data};
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) ptr[i]++;
    if (mh) log_q.push_back(ob);
    if (stall) chk("stall_hold", {m_valid, m_user, m_keep, m_last, m_data}, {1'b1, ob});
    if (bp_on) begin
      m_ready = bp_pat[0];
      bp_pat  = {bp_pat[0], bp_pat[31:1]};
    end
  endtask
  task automatic do_reset;
    bp_on   = 1'b0;
    m_ready = 1'b1;
    rst     = 1'b0;
    step();
    rst = 1'b1;
    clr();
  endtask
  task automatic run_until(input int n, input string tag);
    int k = 0;
    while (log_q.size() < n && k < 300) begin
      step();
      k++;
    end
    chk(tag, 64'(log_q.size()), 64'(n));
  endtask
  initial begin
    clr();
    // reset state
    rst = 1'b0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_idx, 3);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_mdata", {m_user, m_keep, m_last, m_data}, 0);
    rst = 1'b1;
    // single source, lane 2, 3-beat packet
    push(2, bt(32'hA0, 0));
    push(2, bt(32'hA1, 0));
    push(2, bt(32'hA2, 1));
    step();
    chk("t1_grant", grant_idx, 2);
    chk("t1_busy", busy, 1);
    chk("t1_bubble", m_valid, 0);
    chk("t1_sready", s_ready, 4'b0100);
    step();
    chk("t1_b0", {m_valid, m_last, m_data}, {2'b10, 32'hA0});
    step();
    chk("t1_b1", {m_valid, m_last, m_data}, {2'b10, 32'hA1});
    step();
    chk("t1_b2", {m_valid, m_last, m_data}, {2'b11, 32'hA2});
    chk("t1_busy_fall", busy, 0);
    step();
    chk("t1_idle", m_valid, 0);
    // all lanes requesting, 2-beat packets; lane 0 has two packets
    do_reset();
    for (int i = 0; i < N; i++) begin
      push(i, bt(32'(i * 256), 0));
      push(i, bt(32'(i * 256 + 1), 1));
    end
    push(0, bt(32'h010, 0));
    push(0, bt(32'h011, 1));
    exp2 = '{{1'b0, 32'h000}, {1'b1, 32'h001}, {1'b0, 32'h100}, {1'b1, 32'h101},
             {1'b0, 32'h200}, {1'b1, 32'h201}, {1'b0, 32'h300}, {1'b1, 32'h301},
             {1'b0, 32'h010}, {1'b1, 32'h011}};
    run_until(10, "t2_count");
    for (int k = 0; k < 10 && k < log_q.size(); k++) chk("t2_order", log_q[k][32:0], exp2[k]);
    // lane 1 locked, stalls mid-packet while lane 0 waits
    do_reset();
    push(1, bt(32'h110, 0));
    push(1, bt(32'h111, 0));
    push(1, bt(32'h112, 1));
    step();
    chk("t3_grant1", grant_idx, 1);
    push(0, bt(32'h050, 1));
    step();
    hold[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_no_lane0", {busy, s_ready[0]}, 2'b10);
    end
    chk("t3_still1", grant_idx, 1);
    hold[1] = 1'b0;
    run_until(4, "t3_count");
    if (log_q.size() >= 4) begin
      chk("t3_o0", log_q[0][32:0], {1'b0, 32'h110});
      chk("t3_o1", log_q[1][32:0], {1'b0, 32'h111});
      chk("t3_o2", log_q[2][32:0], {1'b1, 32'h112});
      chk("t3_o3", log_q[3][32:0], {1'b1, 32'h050});
    end
    chk("t3_grant0", grant_idx, 0);
    // backpressure on a 16-beat packet from lane 3
    do_reset();
    for (int k = 0; k < 16; k++) push(3, bt(32'(32'h300 + k), k == 15));
    bp_on = 1'b1;
    run_until(16, "t4_count");
    bp_on   = 1'b0;
    m_ready = 1'b1;
    step();
    step();
    step();
    chk("t4_no_dup", 64'(log_q.size()), 16);
    for (int k = 0; k < 16 && k < log_q.size(); k++)
      chk("t4_beat", log_q[k][32:0], {k == 15, 32'(32'h300 + k)});
    // reset in the middle of a 4-beat packet
    do_reset();
    for (int k = 0; k < 4; k++) push(2, bt(32'(32'h520 + k), k == 3));
    step();
    step();
    step();
    chk("t5_pre", {m_valid, m_data}, {1'b1, 32'h521});
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("t5_mvalid", m_valid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_sready", s_ready, 0);
    chk("t5_grant", grant_idx, 3);
    clr();
    push(2, bt(32'h5F0, 1));
    push(0, bt(32'h5E0, 1));
    step();
    chk("t5_first0", grant_idx, 0);
    // single-beat packets from lanes 0 and 3 alternate, keep/user preserved
    do_reset();
    push(0, bt(32'h600, 1, 4'hF, 2'b10));
    push(0, bt(32'h601, 1, 4'hF, 2'b10));
    push(3, bt(32'h630, 1, 4'hF, 2'b10));
    push(3, bt(32'h631, 1, 4'hF, 2'b10));
    run_until(4, "t6_count");
    if (log_q.size() >= 4) begin
      chk("t6_p0", log_q[0], {2'b10, 4'hF, 1'b1, 32'h600});
      chk("t6_p1", log_q[1], {2'b10, 4'hF, 1'b1, 32'h630});
      chk("t6_p2", log_q[2], {2'b10, 4'hF, 1'b1, 32'h601});
      chk("t6_p3", log_q[3], {2'b10, 4'hF, 1'b1, 32'h631});
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
